// File: rtl/rf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module  : rf_wb_queue
// Purpose : In-order writeback queue that drains onto the RF write port, with
//           pending-write lookup for decode. Optional forwarding: WB_QUEUE_FWD_EN
// Revision: 1.0
// ============================================================================
module rf_wb_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [2:0]  wb_regsel,
   input  logic [15:0] wb_data,
   output logic        wb_ready,
   input  logic        rf_hold,
   output logic [2:0]  writeregsel,
   output logic [15:0] writedata,
   output logic        write,
   input  logic [2:0]  chk1regsel,
   input  logic [2:0]  chk2regsel,
   output logic        chk1pend,
   output logic        chk2pend,
   output logic [15:0] chk1data,
   output logic [15:0] chk2data,
   output logic        err
);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [2:0]    regsel_mem [DEPTH];
   logic [15:0]   data_mem   [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          not_empty;
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] hit1;
   logic [DEPTH-1:0] hit2;

   assign not_empty   = (count != '0);
   assign wb_ready    = ~rst & (count != FULL_CNT);
   assign write       = ~rst & not_empty & ~rf_hold;
   assign push        = wb_valid & wb_ready;
   assign pop         = write;
   assign writeregsel = not_empty ? regsel_mem[head] : 3'd0;
   assign writedata   = not_empty ? data_mem[head]   : 16'h0000;

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         err   <= 1'b0;
      end else begin
         if (push) tail <= tail + PTR_ONE;
         if (pop)  head <= head + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         err <= wb_valid & ~wb_ready;
      end
   end

   // Storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (push) begin
         regsel_mem[tail] <= wb_regsel;
         data_mem[tail]   <= wb_data;
      end
   end

   // A slot is live when its distance from head is below the occupancy.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [AW-1:0] offset;
      assign offset   = AW'(i) - head;
      assign valid[i] = ({1'b0, offset} < count);
      assign hit1[i]  = valid[i] & (regsel_mem[i] == chk1regsel);
      assign hit2[i]  = valid[i] & (regsel_mem[i] == chk2regsel);
   end

   assign chk1pend = ~rst & (|hit1);
   assign chk2pend = ~rst & (|hit2);

`ifdef WB_QUEUE_FWD_EN
   logic [AW-1:0] idx;
   logic [15:0]   fwd1;
   logic [15:0]   fwd2;

   // Walk oldest to youngest so the last hit (youngest) wins.
   always_comb begin
      idx  = head;
      fwd1 = 16'h0000;
      fwd2 = 16'h0000;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + AW'(k);
         if (hit1[idx]) fwd1 = data_mem[idx];
         if (hit2[idx]) fwd2 = data_mem[idx];
      end
   end

   assign chk1data = rst ? 16'h0000 : fwd1;
   assign chk2data = rst ? 16'h0000 : fwd2;
`else
   assign chk1data = 16'h0000;
   assign chk2data = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_queue.sv
`default_nettype none
// Testbench for rf_wb_queue: queue-based reference model, negedge monitor.
module tb_rf_wb_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_valid = 1'b0;
   logic [2:0]  wb_regsel = 3'd0;
   logic [15:0] wb_data = 16'h0000;
   logic        wb_ready;
   logic        rf_hold = 1'b0;
   logic [2:0]  writeregsel;
   logic [15:0] writedata;
   logic        write;
   logic [2:0]  chk1regsel = 3'd0;
   logic [2:0]  chk2regsel = 3'd0;
   logic        chk1pend, chk2pend;
   logic [15:0] chk1data, chk2data;
   logic        err;

   rf_wb_queue #(.DEPTH(DEPTH), .AW(2)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_regsel(wb_regsel), .wb_data(wb_data), .wb_ready(wb_ready),
      .rf_hold(rf_hold),
      .writeregsel(writeregsel), .writedata(writedata), .write(write),
      .chk1regsel(chk1regsel), .chk2regsel(chk2regsel),
      .chk1pend(chk1pend), .chk2pend(chk2pend),
      .chk1data(chk1data), .chk2data(chk2data),
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  r;
      logic [15:0] d;
   } ent_t;

   ent_t sb[$];
   bit   acc_ready = 1'b0;
   bit   exp_err   = 1'b0;
   int   checks    = 0;
   int   passes    = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      else
         passes++;
   endtask

   // Reference model: accept into the scoreboard when there was room.
   always @(posedge clk) begin
      if (rst) begin
         sb.delete();
         exp_err = 1'b0;
      end else begin
         exp_err = wb_valid && !acc_ready;
         if (wb_valid && acc_ready) sb.push_back('{r: wb_regsel, d: wb_data});
      end
   end

   // Monitor: compare outputs against the model, pop on each RF write.
   always @(negedge clk) begin
      bit          ew, er, p1, p2;
      logic [15:0] d1, d2;
      ew = !rst && sb.size() != 0 && !rf_hold;
      er = !rst && sb.size() < DEPTH;
      p1 = 1'b0; p2 = 1'b0; d1 = 16'h0; d2 = 16'h0;
      foreach (sb[i]) begin
         if (sb[i].r == chk1regsel) begin p1 = 1'b1; d1 = sb[i].d; end
         if (sb[i].r == chk2regsel) begin p2 = 1'b1; d2 = sb[i].d; end
      end
      if (rst) begin p1 = 1'b0; p2 = 1'b0; d1 = 16'h0; d2 = 16'h0; end
`ifndef WB_QUEUE_FWD_EN
      d1 = 16'h0; d2 = 16'h0;
`endif
      check("write",    32'(write),    32'(ew));
      check("wb_ready", 32'(wb_ready), 32'(er));
      check("err",      32'(err),      32'(exp_err));
      check("chk1pend", 32'(chk1pend), 32'(p1));
      check("chk2pend", 32'(chk2pend), 32'(p2));
      check("chk1data", 32'(chk1data), 32'(d1));
      check("chk2data", 32'(chk2data), 32'(d2));
      if (write === 1'b1 && ew) begin
         check("writeregsel", 32'(writeregsel), 32'(sb[0].r));
         check("writedata",   32'(writedata),   32'(sb[0].d));
         void'(sb.pop_front());
      end
      acc_ready = er;
   end

   task automatic drive(input bit r, input bit v, input logic [2:0] rs,
                        input logic [15:0] d, input bit h);
      @(posedge clk);
      #1;
      rst = r; wb_valid = v; wb_regsel = rs; wb_data = d; rf_hold = h;
   endtask

   initial begin
      // reset held two cycles with a request present
      drive(1, 1, 3'd5, 16'h5555, 0);
      drive(1, 1, 3'd5, 16'h5555, 0);
      drive(0, 0, 3'd0, 16'h0, 0);
      drive(0, 0, 3'd0, 16'h0, 0);

      // single entry and its lookup window
      chk1regsel = 3'd3;
      drive(0, 1, 3'd3, 16'hBEEF, 0);
      repeat (3) drive(0, 0, 3'd0, 16'h0, 0);

      // fill under hold, overflow on the fifth, then drain
      for (int i = 1; i <= 5; i++) drive(0, 1, 3'(i), 16'h1000 + 16'(i), 1);
      repeat (6) drive(0, 0, 3'd0, 16'h0, 0);

      // full queue with continuous push while draining (pointer wrap)
      for (int i = 0; i < 4; i++) drive(0, 1, 3'(i), 16'h2000 + 16'(i), 1);
      for (int i = 4; i < 14; i++) drive(0, 1, 3'(i), 16'h2000 + 16'(i), 0);
      repeat (6) drive(0, 0, 3'd0, 16'h0, 0);

      // duplicate register lookup
      chk2regsel = 3'd2;
      drive(0, 1, 3'd2, 16'h1111, 1);
      drive(0, 1, 3'd2, 16'h2222, 1);
      drive(0, 0, 3'd0, 16'h0, 1);
      repeat (4) drive(0, 0, 3'd0, 16'h0, 0);

      // reset mid-drain
      for (int i = 0; i < 3; i++) drive(0, 1, 3'(i + 4), 16'h3000 + 16'(i), 1);
      drive(0, 0, 3'd0, 16'h0, 0);
      drive(1, 0, 3'd0, 16'h0, 0);
      repeat (3) drive(0, 0, 3'd0, 16'h0, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         chk1regsel = 3'($urandom_range(0, 7));
         chk2regsel = 3'($urandom_range(0, 7));
         drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 60),
               3'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 99) < 40));
      end
      repeat (8) drive(0, 0, 3'd0, 16'h0, 0);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
